ok_trigger_out_wide: RTL and testbench
======================================

# ok_trigger_out_wide

Parametrised trigger-out endpoint: detects edges on a WIDTH-bit trigger vector, accumulates them between host update strobes, and presents the snapshot to the host as consecutive 16-bit words in the 0x60–0x7F trigger-out address space. It adds a per-word overflow status word and a pending flag. It sits between user logic and the host interface decode, in a single clock domain.

## Interface
- WIDTH, 64, trigger bits; multiple of 16, range 16..240; WORDS = WIDTH/16.
- BASE_ADDR, 8'h60, address of word 0; word k at BASE_ADDR+k, status word at BASE_ADDR+WORDS.
- EDGE, 0, detection mode: 0 rising, 1 falling, 2 both.
- Elaboration error if WIDTH is illegal, or if BASE_ADDR < 0x60, or if BASE_ADDR+WORDS > 0x7F.

Ports:
- ti_clock  in  1  sole clock; all logic on rising edge.
- ti_reset_n  in  1  asynchronous assert, active-low reset.
- ti_addr  in  8  host endpoint address.
- ti_trigupdate  in  1  one-cycle host strobe; snapshot accumulator.
- ep_trigger  in  WIDTH  user trigger vector, synchronous to ti_clock.
- ok_dataout  out  16  registered readback word; 0 when ti_addr is not in range.
- ok_ready  out  1  high the cycle after ti_addr is in range, i.e. when ok_dataout is valid for it.
- trig_pending  out  1  OR of the accumulator; intended as host-interrupt hint.

## Operation
- Registers:
  - prev[WIDTH]: last sample.
  - primed: cleared by reset, set after the first post-reset cycle.
  - acc[WIDTH]: accumulator.
  - hold[WIDTH]: snapshot.
  - ovf_acc[WORDS] and ovf_hold[WORDS]: overflow flags.
- Edge vector e = rising (ep_trigger & ~prev), falling (~ep_trigger & prev), or both (ep_trigger ^ prev), chosen by EDGE; e is forced to 0 while primed=0. A level already present at reset release therefore produces no edge.
- prev <= ep_trigger every cycle.
- No strobe: acc <= acc | e. For each word k, ovf_acc[k] sets if any bit has e=1 while acc=1 already (edge lost); it is sticky.
- ti_trigupdate=1 in the same cycle:
  - hold <= acc | e and ovf_hold <= ovf_acc | new overflow, so edges that cycle are included in the snapshot, not lost.
  - acc <= 0 and ovf_acc <= 0.
- Strobe with no intervening edges: hold becomes 0. Reading is non-destructive; hold changes only on a strobe.
- Readback, registered once:
  - ti_addr = BASE_ADDR+k (k<WORDS): ok_dataout <= hold[16k+15:16k].
  - ti_addr = BASE_ADDR+WORDS: ok_dataout <= {hold!=0, zero pad, ovf_hold[WORDS-1:0]}. Bit 15 is nonempty; bits [WORDS-1:0] are overflow flags; all other bits 0.
  - Otherwise ok_dataout <= 0 and ok_ready <= 0.
- trig_pending = |acc (combinational from register).

## Timing
- Reset (ti_reset_n=0, async): prev, acc, hold, ovf_acc, ovf_hold, primed, ok_dataout, ok_ready all 0; trig_pending 0. Reset mid-accumulation discards everything.
- Edge latency: ep_trigger change at cycle n is reflected in acc and trig_pending at edge n+1.
- Snapshot: strobe sampled at edge n; hold is valid after edge n. A read with ti_addr stable from cycle n gives ok_dataout/ok_ready after edge n+1.
- Back-to-back strobes are legal; each closes one interval.
- ti_addr changes take effect with 1-cycle latency; no wait states otherwise.

## Test plan
- Reset with ep_trigger=16'hFFFF on word 0, release, hold 5 cycles, strobe, read 0x60 -> ok_dataout 0x0000, trig_pending stayed 0 (priming).
- EDGE=0, WIDTH=64: pulse bit 0 and bit 47 one cycle each, strobe, read 0x60..0x64 -> 0x0001, 0, 0x8000, 0, status 0x8000; ok_ready=1 each read, 0 at addr 0x65.
- Two rising edges on bit 20 before a strobe -> word 1 = 0x0010, status = 0x8002. Next strobe with no edges -> status 0x0000.
- Rising edge on bit 3 in the same cycle as ti_trigupdate -> bit 3 in hold (word 0 = 0x0008), acc = 0 afterwards.
- EDGE=2: ep_trigger bit 5 rises then falls before a strobe -> overflow set for word 0 (status 0x8001). EDGE=1: the same stimulus -> word 0 = 0x0020, no overflow.
- Assert ti_reset_n low mid-interval with acc nonzero -> all outputs 0 within the reset cycle; after release, a strobe reads all zero.

Source files
------------

// File: rtl/ok_trigger_out_wide.sv
// Wide trigger-out endpoint: edge-detects a WIDTH-bit trigger vector, accumulates
// edges between host update strobes and serves the snapshot as 16-bit words.
module ok_trigger_out_wide #(
    parameter int unsigned WIDTH     = 64,
    parameter logic [7:0]  BASE_ADDR = 8'h60,
    parameter int unsigned EDGE      = 0
) (
    input  logic             ti_clock,
    input  logic             ti_reset_n,
    input  logic [7:0]       ti_addr,
    input  logic             ti_trigupdate,
    input  logic [WIDTH-1:0] ep_trigger,
    output logic [15:0]      ok_dataout,
    output logic             ok_ready,
    output logic             trig_pending
);

    localparam int unsigned WORDS     = WIDTH / 16;
    localparam int unsigned LAST_ADDR = 32'(BASE_ADDR) + WORDS;

    if (WIDTH < 16 || WIDTH > 240 || (WIDTH % 16) != 0) begin : g_bad_width
        $error("ok_trigger_out_wide: WIDTH must be a multiple of 16 in 16..240");
    end
    if (BASE_ADDR < 8'h60 || LAST_ADDR > 32'h7F) begin : g_bad_addr
        $error("ok_trigger_out_wide: address window must lie within 0x60..0x7F");
    end
    if (EDGE > 2) begin : g_bad_edge
        $error("ok_trigger_out_wide: EDGE must be 0, 1 or 2");
    end

    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] hold;
    logic [WORDS-1:0] ovf_acc;
    logic [WORDS-1:0] ovf_hold;
    logic             primed;

    logic [WIDTH-1:0] edges_c;
    logic [WIDTH-1:0] acc_next_c;
    logic [WORDS-1:0] ovf_new_c;
    logic [15:0]      rd_data_c;
    logic             rd_hit_c;

    // Edge detection; suppressed until one sample after reset so held levels are ignored
    always_comb begin
        edges_c = '0;
        if (primed) begin
            if (EDGE == 0) begin
                edges_c = ep_trigger & ~prev;
            end else if (EDGE == 1) begin
                edges_c = ~ep_trigger & prev;
            end else begin
                edges_c = ep_trigger ^ prev;
            end
        end
        acc_next_c = acc | edges_c;
        for (int unsigned k = 0; k < WORDS; k++) begin
            ovf_new_c[k] = |(edges_c[16*k +: 16] & acc[16*k +: 16]);
        end
    end

    // Readback decode: data words, then the status word just past them
    always_comb begin
        rd_data_c = '0;
        rd_hit_c  = 1'b0;
        for (int unsigned k = 0; k < WORDS; k++) begin
            if (ti_addr == BASE_ADDR + 8'(k)) begin
                rd_data_c = hold[16*k +: 16];
                rd_hit_c  = 1'b1;
            end
        end
        if (ti_addr == BASE_ADDR + 8'(WORDS)) begin
            rd_data_c                = '0;
            rd_data_c[15]            = |hold;
            rd_data_c[WORDS-1:0]     = ovf_hold;
            rd_hit_c                 = 1'b1;
        end
    end

    // Strobe snapshots the accumulator including this cycle's edges and restarts it
    always_ff @(posedge ti_clock or negedge ti_reset_n) begin
        if (!ti_reset_n) begin
            prev       <= '0;
            acc        <= '0;
            hold       <= '0;
            ovf_acc    <= '0;
            ovf_hold   <= '0;
            primed     <= 1'b0;
            ok_dataout <= '0;
            ok_ready   <= 1'b0;
        end else begin
            primed <= 1'b1;
            prev   <= ep_trigger;
            if (ti_trigupdate) begin
                hold     <= acc_next_c;
                ovf_hold <= ovf_acc | ovf_new_c;
                acc      <= '0;
                ovf_acc  <= '0;
            end else begin
                acc     <= acc_next_c;
                ovf_acc <= ovf_acc | ovf_new_c;
            end
            ok_dataout <= rd_data_c;
            ok_ready   <= rd_hit_c;
        end
    end

    assign trig_pending = |acc;

endmodule

// File: tb/tb_ok_trigger_out_wide.sv
// Directed bench for ok_trigger_out_wide: one instance per edge mode sharing stimulus,
// readback expectations queued at address drive and checked when the word appears.
module tb_ok_trigger_out_wide;

    localparam int unsigned WIDTH = 64;

    logic             ti_clock = 1'b0;
    logic             ti_reset_n;
    logic [7:0]       ti_addr;
    logic             ti_trigupdate;
    logic [WIDTH-1:0] ep_trigger;

    logic [15:0] dout [3];
    logic        rdy  [3];
    logic        pend [3];

    ok_trigger_out_wide #(.WIDTH(WIDTH), .BASE_ADDR(8'h60), .EDGE(0)) dut_rise (
        .ti_clock(ti_clock), .ti_reset_n(ti_reset_n), .ti_addr(ti_addr),
        .ti_trigupdate(ti_trigupdate), .ep_trigger(ep_trigger),
        .ok_dataout(dout[0]), .ok_ready(rdy[0]), .trig_pending(pend[0]));

    ok_trigger_out_wide #(.WIDTH(WIDTH), .BASE_ADDR(8'h60), .EDGE(1)) dut_fall (
        .ti_clock(ti_clock), .ti_reset_n(ti_reset_n), .ti_addr(ti_addr),
        .ti_trigupdate(ti_trigupdate), .ep_trigger(ep_trigger),
        .ok_dataout(dout[1]), .ok_ready(rdy[1]), .trig_pending(pend[1]));

    ok_trigger_out_wide #(.WIDTH(WIDTH), .BASE_ADDR(8'h60), .EDGE(2)) dut_both (
        .ti_clock(ti_clock), .ti_reset_n(ti_reset_n), .ti_addr(ti_addr),
        .ti_trigupdate(ti_trigupdate), .ep_trigger(ep_trigger),
        .ok_dataout(dout[2]), .ok_ready(rdy[2]), .trig_pending(pend[2]));

    always #5 ti_clock = ~ti_clock;

    typedef struct {
        int          dut;
        logic [15:0] data;
        logic        ready;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge ti_clock);
    endtask

    task automatic strobe();
        ti_trigupdate = 1'b1;
        tick();
        ti_trigupdate = 1'b0;
    endtask

    task automatic pulse(input int bit_idx);
        ep_trigger[bit_idx] = 1'b1;
        tick();
        ep_trigger[bit_idx] = 1'b0;
        tick();
    endtask

    // Drive the address, queue the expectation, compare once the registered word is out
    task automatic rd(input int d, input logic [7:0] a, input logic [15:0] data,
                      input logic ready, input string tag);
        exp_t e;
        exp_t got;
        e.dut = d; e.data = data; e.ready = ready; e.tag = tag;
        ti_addr = a;
        q.push_back(e);
        tick();
        got = q.pop_front();
        check(got.tag, {15'b0, rdy[got.dut], dout[got.dut]}, {15'b0, got.ready, got.data});
    endtask

    initial begin
        ti_reset_n    = 1'b0;
        ti_addr       = 8'h00;
        ti_trigupdate = 1'b0;
        ep_trigger    = '0;
        ep_trigger[15:0] = 16'hFFFF;
        repeat (3) tick();
        check("reset_outputs", {14'b0, pend[0], rdy[0], dout[0]}, 32'h0);

        // Level already high at reset release must not count as an edge
        ti_reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("prime_pending_%0d", i), {31'b0, pend[0]}, 32'h0);
        end
        strobe();
        rd(0, 8'h60, 16'h0000, 1'b1, "prime_word0");

        // Clear the falling edges the mode-1/2 instances see when the level drops
        ep_trigger = '0;
        tick();
        strobe();

        pulse(0);
        pulse(47);
        check("pending_after_pulses", {31'b0, pend[0]}, 32'h1);
        strobe();
        check("pending_after_strobe", {31'b0, pend[0]}, 32'h0);
        rd(0, 8'h60, 16'h0001, 1'b1, "pulse_word0");
        rd(0, 8'h61, 16'h0000, 1'b1, "pulse_word1");
        rd(0, 8'h62, 16'h8000, 1'b1, "pulse_word2");
        rd(0, 8'h63, 16'h0000, 1'b1, "pulse_word3");
        rd(0, 8'h64, 16'h8000, 1'b1, "pulse_status");
        rd(0, 8'h65, 16'h0000, 1'b0, "out_of_range");
        rd(0, 8'h60, 16'h0001, 1'b1, "reread_word0");

        // Two rising edges on one bit within an interval flag overflow for that word
        pulse(20);
        pulse(20);
        strobe();
        rd(0, 8'h61, 16'h0010, 1'b1, "ovf_word1");
        rd(0, 8'h64, 16'h8002, 1'b1, "ovf_status");
        strobe();
        rd(0, 8'h64, 16'h0000, 1'b1, "empty_status");
        rd(0, 8'h61, 16'h0000, 1'b1, "empty_word1");

        // Edge arriving in the strobe cycle lands in the snapshot, not the next interval
        ep_trigger[3] = 1'b1;
        strobe();
        check("same_cycle_acc_clear", {31'b0, pend[0]}, 32'h0);
        rd(0, 8'h60, 16'h0008, 1'b1, "same_cycle_word0");
        ep_trigger[3] = 1'b0;
        tick();
        strobe();

        pulse(5);
        strobe();
        rd(2, 8'h64, 16'h8001, 1'b1, "both_status");
        rd(2, 8'h60, 16'h0020, 1'b1, "both_word0");
        rd(1, 8'h60, 16'h0020, 1'b1, "fall_word0");
        rd(1, 8'h64, 16'h8000, 1'b1, "fall_status");
        rd(0, 8'h64, 16'h8000, 1'b1, "rise_status");

        // Asynchronous reset mid-interval discards accumulator and snapshot
        pulse(10);
        check("pre_reset_pending", {31'b0, pend[0]}, 32'h1);
        ti_reset_n = 1'b0;
        #1;
        check("async_reset_outputs", {14'b0, pend[0], rdy[0], dout[0]}, 32'h0);
        tick();
        ti_reset_n = 1'b1;
        repeat (2) tick();
        strobe();
        rd(0, 8'h62, 16'h0000, 1'b1, "post_reset_word2");
        rd(0, 8'h64, 16'h0000, 1'b1, "post_reset_status");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
